imem_loader: RTL and testbench

Boot-time writer for the instruction memory. Accepts a byte stream (e.g. from a UART receiver) carrying a length header, payload and optional checksum. Assembles bytes little-endian into 32-bit words and issues single-cycle word writes at consecutive word-aligned byte addresses. Holds the core in reset while loading and flags completion or error.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_word_assembler.sv | 46 ++++
 rtl/imem_loader.sv | 209 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CKSUM_EN.
package imem_loader_pkg;

  localparam int HDR_BYTES   = 4;
  localparam int CKSUM_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_FIN
`ifdef IMEM_LOADER_CKSUM_EN
    , ST_CKSUM
`endif
  } imem_loader_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word assembler; the first byte of each group of four
// ends up in word[7:0]. word/word_valid present the completed word on the accepting edge.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        accept,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int WORD_BYTES = (HDR_BYTES > CKSUM_BYTES) ? HDR_BYTES : CKSUM_BYTES;

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] bytes_q, bytes_d;

  // Only the three most recent bytes need storage; the fourth is live on byte_in.
  assign word       = {byte_in, bytes_q};
  assign word_valid = accept && (cnt_q == 2'(WORD_BYTES - 1));

  always_comb begin
    cnt_d   = cnt_q;
    bytes_d = bytes_q;
    if (clear) begin
      cnt_d   = '0;
      bytes_d = '0;
    end else if (accept) begin
      cnt_d   = cnt_q + 2'd1;
      bytes_d = word[31:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bytes_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: length header, payload, optional checksum
// trailer (IMEM_LOADER_CKSUM_EN). Holds the core in reset while loading.
//
// state    | meaning
// ST_IDLE  | waiting for start, rx_ready low
// ST_LEN   | collecting the 4-byte little-endian length
// ST_DATA  | collecting payload words, one write per word
// ST_CKSUM | collecting and comparing the 4-byte checksum trailer
// ST_FIN   | drops busy, raises done, returns to idle
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int DEPTH = 8192,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold
);

  localparam int RW = AW - 1;

  imem_loader_state_t state_q, state_d;
  logic          rx_ready_q, rx_ready_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [RW-1:0] remain_q, remain_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0]   sum_q, sum_d;
`endif

  logic        accept;
  logic        asm_clear;
  logic [31:0] word;
  logic        word_valid;

  assign accept = rx_valid && rx_ready_q;

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (rx_data),
    .accept     (accept),
    .clear      (asm_clear),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d    = state_q;
    rx_ready_d = rx_ready_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    remain_d   = remain_q;
    asm_clear  = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    sum_d      = sum_q;
`endif

    // Advance after each write except the last, so waddr stops at DEPTH-4.
    if (we_q && (remain_q != '0)) begin
      waddr_d = waddr_q + AW'(4);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LEN;
          rx_ready_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          waddr_d    = '0;
          asm_clear  = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
          sum_d      = '0;
`endif
        end
      end

      ST_LEN: begin
        if (word_valid) begin
          remain_d = word[AW:2];
          if ((word[1:0] != 2'b00) || (word > 32'(DEPTH))) begin
            // Error exit with nothing pending: drop busy on this edge.
            state_d    = ST_FIN;
            err_d      = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            rx_ready_d = 1'b0;
          end else if (word == '0) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d    = ST_CKSUM;
`else
            state_d    = ST_FIN;
            rx_ready_d = 1'b0;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (word_valid) begin
          we_d     = 1'b1;
          wdata_d  = word;
          remain_d = remain_q - RW'(1);
`ifdef IMEM_LOADER_CKSUM_EN
          sum_d    = sum_q + word;
`endif
          if (remain_q == RW'(1)) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d    = ST_CKSUM;
`else
            state_d    = ST_FIN;
            rx_ready_d = 1'b0;
`endif
          end
        end
      end

`ifdef IMEM_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (word_valid) begin
          state_d    = ST_FIN;
          rx_ready_d = 1'b0;
          if (word != sum_q) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
`endif

      ST_FIN: begin
        state_d    = ST_IDLE;
        rx_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end

      default: begin
        state_d    = ST_IDLE;
        rx_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      remain_q   <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      remain_q   <= remain_d;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign rx_ready = rx_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = busy_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; checksum cases run when IMEM_LOADER_CKSUM_EN is defined.
module tb_imem_loader;

  localparam int DEPTH = 8192;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready, we, busy, done, err, cpu_hold;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && we) begin
      wr_addr.push_back(32'(waddr));
      wr_data.push_back(wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $display("FAIL %s: observed timeout expected event within bound", tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) timeout("rx_ready");
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) timeout(tag);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Length-8 stream: 08 00 00 00 | 13 00 00 00 | 93 00 10 00 (+ trailer).
  task automatic load_test_stream(input bit gaps, input bit mid_start, input logic [31:0] trailer);
    logic [7:0] bytes [12];
    bytes = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00};
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      if (mid_start && i == 6) pulse_start();
      send_byte(bytes[i], gaps ? int'($urandom_range(0, 3)) : 0);
    end
`ifdef IMEM_LOADER_CKSUM_EN
    for (int i = 0; i < 4; i++) send_byte(trailer[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
`else
    if (trailer != trailer) $display("unreachable");
`endif
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    check({tag, "_a0"}, wr_addr[0], 32'h0);
    check({tag, "_d0"}, wr_data[0], 32'h0000_0013);
    check({tag, "_a1"}, wr_addr[1], 32'h4);
    check({tag, "_d1"}, wr_data[1], 32'h0010_0093);
  endtask

  initial begin
    logic [31:0] sum;

    idle(3);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_we",       32'(we),       32'd0);
    check("rst_waddr",    32'(waddr),    32'd0);
    check("rst_wdata",    wdata,         32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic length-8 load; checks latencies around start and the final write.
    clear_log();
    pulse_start();
    check("start_busy",     32'(busy),     32'd1);
    check("start_rx_ready", 32'(rx_ready), 32'd1);
    check("start_cpu_hold", 32'(cpu_hold), 32'd1);
    send_word(32'h0000_0008);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
`ifdef IMEM_LOADER_CKSUM_EN
    send_word(32'h0010_00A6);
`else
    check("last_we", 32'(we), 32'd1);
`endif
    check("last_busy_m1", 32'(busy), 32'd1);
    idle(1);
    check("last_busy_m2", 32'(busy), 32'd0);
    check("last_done_m2", 32'(done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check_two_writes("t1");
    idle(3);

    // Misaligned length: immediate error exit.
    clear_log();
    pulse_start();
    send_word(32'h0000_0006);
    check("len6_busy", 32'(busy), 32'd0);
    check("len6_done", 32'(done), 32'd1);
    check("len6_err",  32'(err),  32'd1);
    check("len6_rdy",  32'(rx_ready), 32'd0);
    idle(2);
    check("len6_nwr", 32'(wr_addr.size()), 32'd0);

    // Oversize length.
    clear_log();
    pulse_start();
    send_word(32'(DEPTH + 4));
    wait_done("big_done");
    check("big_err", 32'(err), 32'd1);
    idle(2);
    check("big_nwr", 32'(wr_addr.size()), 32'd0);

    // Full-depth load, word i = i.
    clear_log();
    pulse_start();
    send_word(32'(DEPTH));
    sum = '0;
    for (int i = 0; i < DEPTH / 4; i++) begin
      send_word(32'(i));
      sum = sum + 32'(i);
    end
`ifdef IMEM_LOADER_CKSUM_EN
    send_word(sum);
`endif
    wait_done("full_done");
    check("full_err", 32'(err), 32'd0);
    check("full_nwr", 32'(wr_addr.size()), 32'(DEPTH / 4));
    check("full_last_a", wr_addr[wr_addr.size() - 1], 32'(DEPTH - 4));
    check("full_last_d", wr_data[wr_data.size() - 1], 32'(DEPTH / 4 - 1));
    idle(3);

    // Gapped stream with a stray start pulse mid-load.
    clear_log();
    load_test_stream(1'b1, 1'b1, 32'h0010_00A6);
    wait_done("gap_done");
    check("gap_err", 32'(err), 32'd0);
    check_two_writes("gap");
    idle(3);

    // Reset after five payload bytes.
    clear_log();
    pulse_start();
    send_word(32'h0000_0008);
    send_word(32'h0000_0013);
    send_byte(8'h93, 0);
    rst_n = 1'b0;
    #1;
    check("arst_busy",     32'(busy),     32'd0);
    check("arst_rx_ready", 32'(rx_ready), 32'd0);
    check("arst_we",       32'(we),       32'd0);
    check("arst_waddr",    32'(waddr),    32'd0);
    check("arst_wdata",    wdata,         32'd0);
    check("arst_cpu_hold", 32'(cpu_hold), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    clear_log();
    load_test_stream(1'b0, 1'b0, 32'h0010_00A6);
    wait_done("post_rst_done");
    check("post_rst_err", 32'(err), 32'd0);
    check_two_writes("post_rst");
    idle(3);

`ifdef IMEM_LOADER_CKSUM_EN
    // Bad trailer: writes still land, err set.
    clear_log();
    load_test_stream(1'b0, 1'b0, 32'h0010_00A7);
    wait_done("badck_done");
    check("badck_err", 32'(err), 32'd1);
    check_two_writes("badck");
    idle(3);
`endif

    // Zero-length load.
    clear_log();
    pulse_start();
    send_word(32'h0000_0000);
`ifdef IMEM_LOADER_CKSUM_EN
    send_word(32'h0000_0000);
`endif
    wait_done("len0_done");
    check("len0_err", 32'(err), 32'd0);
    idle(2);
    check("len0_nwr", 32'(wr_addr.size()), 32'd0);
    check("len0_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
